aes_decrypt_iter: RTL

- Iterative AES-128 inverse cipher: the decryption counterpart of the team's AES encryption top.
- Takes a 128-bit ciphertext and 128-bit cipher key, and returns the plaintext.
- Runs one round per clock, with the key schedule computed on the fly.
- Sits beside the encryption core; the byte order of in/out/key matches it (bit 127 = byte 0, FIPS-197 order).

---
 rtl/aes_pkg.sv | 98 +++++++++
 rtl/aes_inv_round.sv | 43 ++++
 rtl/aes_decrypt_iter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box/Rcon tables, GF(2^8) helpers and key-schedule steps.
// Byte 0 of every block or word sits in the most significant bits.
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2
  } state_t;

  localparam int NR128 = 10;

  // Index 0 and 11..15 are padding so any 4-bit index is in range.
  localparam byte_t RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic byte_t xtime(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(byte_t a, byte_t b);
    byte_t p = 8'h00;
    byte_t x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic word_t sub_rot_word(word_t w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic block_t key_step_fwd(block_t rk, byte_t rc);
    word_t n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undoes key_step_fwd: rc must be the Rcon that produced rk.
  function automatic block_t key_step_inv(block_t rk, byte_t rc);
    word_t w0, w1, w2, w3;
    w3 = rk[31:0]  ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] nxt
);

  function automatic word_t inv_mix_col(word_t c);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  logic [127:0] ark;

  // Row r of column c is taken from column (c - r) mod 4 of the input.
  always_comb begin
    ark = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127 - 8*(4*c + r) -: 8] = INV_SBOX[st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]]
                                      ^ rk[127 - 8*(4*c + r) -: 8];
      end
    end
  end

  always_comb begin
    nxt = ark;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        nxt[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
      end
    end
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one round per clock, key schedule expanded on the fly.
// Latency 20 clocks start-to-done (10 on a key-cache hit with AES_DEC_KEY_CACHE_EN).
// No backpressure: start is only sampled in IDLE; requests while busy are dropped.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] out
);

  generate
    if (NR != NR128) begin : g_nr_check
      $error("aes_decrypt_iter supports only NR=10");
    end
  endgenerate

  state_t       state, state_nxt;
  logic [127:0] st, st_nxt;
  logic [127:0] rk, rk_nxt;
  logic [3:0]   rcon_idx, rcon_idx_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] out_nxt;
  logic         busy_nxt, done_nxt;

  logic [127:0] rk_fwd, rk_inv, round_out;

  assign rk_fwd = key_step_fwd(rk, RCON[rcon_idx]);
  assign rk_inv = key_step_inv(rk, RCON[rnd + 4'd1]);

  aes_inv_round u_round (
    .st   (st),
    .rk   (rk_inv),
    .last (rnd == 4'd0),
    .nxt  (round_out)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key, cache_key_nxt;
  logic [127:0] cache_rk10, cache_rk10_nxt;
  logic         cache_vld, cache_vld_nxt;
  logic         cache_hit;

  assign cache_hit = cache_vld && (key == cache_key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_key  <= '0;
      cache_rk10 <= '0;
      cache_vld  <= 1'b0;
    end else begin
      cache_key  <= cache_key_nxt;
      cache_rk10 <= cache_rk10_nxt;
      cache_vld  <= cache_vld_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    st_nxt       = st;
    rk_nxt       = rk;
    rcon_idx_nxt = rcon_idx;
    rnd_nxt      = rnd;
    out_nxt      = out;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_key_nxt  = cache_key;
    cache_rk10_nxt = cache_rk10;
    cache_vld_nxt  = cache_vld;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_hit) begin
            rk_nxt    = cache_rk10;
            st_nxt    = in ^ cache_rk10;
            rnd_nxt   = 4'd9;
            state_nxt = ROUND;
          end else begin
            // Key is remembered now; the entry only becomes valid once rk10 exists.
            cache_key_nxt = key;
            cache_vld_nxt = 1'b0;
            st_nxt        = in;
            rk_nxt        = key;
            rcon_idx_nxt  = 4'd1;
            state_nxt     = KEYEXP;
          end
`else
          st_nxt       = in;
          rk_nxt       = key;
          rcon_idx_nxt = 4'd1;
          state_nxt    = KEYEXP;
`endif
        end
      end
      KEYEXP: begin
        rk_nxt       = rk_fwd;
        rcon_idx_nxt = rcon_idx + 4'd1;
        if (rcon_idx == 4'd10) begin
          st_nxt    = st ^ rk_fwd;
          rnd_nxt   = 4'd9;
          state_nxt = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_rk10_nxt = rk_fwd;
          cache_vld_nxt  = 1'b1;
`endif
        end
      end
      ROUND: begin
        rk_nxt = rk_inv;
        if (rnd == 4'd0) begin
          out_nxt   = round_out;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          st_nxt  = round_out;
          rnd_nxt = rnd - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      st       <= '0;
      rk       <= '0;
      rcon_idx <= '0;
      rnd      <= '0;
      out      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      st       <= st_nxt;
      rk       <= rk_nxt;
      rcon_idx <= rcon_idx_nxt;
      rnd      <= rnd_nxt;
      out      <= out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule
